uart_tx: RTL and testbench

- UART transmitter that drains the transceiver's TX FIFO. It is the read-side consumer of the FIFO, feeding the line-side serializer.
- Pops one word per frame when the FIFO reports data.
- Serializes each word LSB-first onto a single line as: start bit, DataWidth data bits, optional parity bit, StopBits stop bits.
- Sits between the TX FIFO (synchronous-read RAM, one-cycle read latency) and the pad.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_counter.sv | 54 +++++
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents: the transmitter state encoding, the default bit-period divider,
// the parity mode constants, and the parity helper function used when a
// word is fetched.
package uart_pkg;

  // Transmitter FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  // 100 MHz system clock / 115200 baud.
  localparam int unsigned CLK_DIV_DEFAULT = 32'd868;

  // Parity mode selectors for the ParityOdd parameter.
  localparam int unsigned PARITY_EVEN = 32'd0;
  localparam int unsigned PARITY_ODD  = 32'd1;

  // Parity of a word of up to 32 bits. Zero-extended upper bits do not
  // change the XOR, so narrower words may be passed through a size cast.
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   clear_i    - hold the counter at zero (used while no bit is on the line)
//   bit_done_o - registered one-cycle pulse on the last cycle of each bit period
// The counter wraps from ClkDiv-1 back to 0 by itself, so every new bit
// period starts from zero without an explicit clear.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned ClkDiv = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int unsigned CW = (ClkDiv > 32'd1) ? $clog2(ClkDiv) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(ClkDiv - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Next count: hold at zero on clear, wrap at the end of a bit period.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Flag the cycle in which the counter will sit on its last value.
    done_d = (cnt_d == LAST);
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bit_done_o = done_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining the TX FIFO onto the serial pad.
// Frame: start bit, DataWidth data bits LSB first, optional parity bit,
// StopBits stop bits. One FIFO pop per frame.
// Ports:
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   tx_enable     - permits starting new frames (never truncates one)
//   fifo_data     - FIFO read data, valid one cycle after has_data
//   fifo_has_data - FIFO non-empty
//   fifo_read     - one-cycle pop strobe, high during FETCH only
//   tx            - serial line, idle high, registered
//   busy          - high whenever the FSM is not IDLE, registered
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned ClkDiv    = CLK_DIV_DEFAULT,
  parameter int unsigned DataWidth = 32'd8,
  parameter int unsigned ParityEn  = 32'd0,
  parameter int unsigned ParityOdd = PARITY_EVEN,
  parameter int unsigned StopBits  = 32'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_enable,
  input  logic [DataWidth-1:0] fifo_data,
  input  logic                 fifo_has_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned IW = (DataWidth > 32'd1) ? $clog2(DataWidth) : 32'd1;
  localparam logic [IW-1:0] LAST_BIT  = IW'(DataWidth - 32'd1);
  localparam logic          LAST_STOP = 1'(StopBits - 32'd1);
  localparam logic          ODD_SEL   = (ParityOdd == PARITY_ODD);

  uart_state_e          state_q, state_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_q, tx_d;
  logic                 fifo_read_q, fifo_read_d;
  logic                 busy_q, busy_d;

  logic                 baud_clear_s;
  logic                 bit_done_s;
  logic                 start_ok_s;

  uart_baud_counter #(
    .ClkDiv(ClkDiv)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (baud_clear_s),
    .bit_done_o(bit_done_s)
  );

  assign start_ok_s = fifo_has_data & tx_enable;

  // Next-state logic for the frame sequencer, shift register and parity.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    baud_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_clear_s = 1'b1;
        if (start_ok_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Read data is valid now; the counter is still held at zero so
        // the start bit gets a full period.
        baud_clear_s = 1'b1;
        shift_d      = fifo_data;
        parity_d     = calc_parity(32'(fifo_data), ODD_SEL);
        bit_idx_d    = '0;
        stop_idx_d   = 1'b0;
        state_d      = ST_START;
      end
      ST_START: begin
        if (bit_done_s) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            stop_idx_d = 1'b0;
            state_d    = (ParityEn != 32'd0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            state_d   = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_done_s) begin
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          if (stop_idx_q == LAST_STOP) begin
            // Chain straight into the next frame when more data waits.
            if (start_ok_s) begin
              state_d = ST_FETCH;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
            state_d    = ST_STOP;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        baud_clear_s = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Output values decoded from the upcoming state so they can be registered.
  always_comb begin
    tx_d        = 1'b1;
    fifo_read_d = (state_d == ST_FETCH);
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
    end
  end

  assign tx        = tx_q;
  assign fifo_read = fifo_read_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Three instances (no parity, even parity,
// odd parity; ClkDiv=4, 8 data bits, 1 stop bit) each get a FIFO model and a
// scoreboard of expected words. A cycle model predicts FETCH, the frame bit
// under way, tx, busy and fifo_read for every cycle; outputs are sampled on
// the falling clock edge.
module tb_uart_tx;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_enable = 1'b0;
  logic [7:0] fdata [3];
  logic       fhas [3];
  logic       tx_w [3];
  logic       rd_w [3];
  logic       busy_w [3];

  logic [7:0] fq [3][$];
  logic [7:0] exp_q [3][$];
  int         mc [3];
  logic       mf [3];
  logic       fr [3][12];
  int         flen [3];
  int         par_en [3];
  int         par_odd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.ClkDiv(CD), .DataWidth(8), .ParityEn(0), .ParityOdd(0), .StopBits(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_data(fdata[0]),
    .fifo_has_data(fhas[0]), .fifo_read(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx #(.ClkDiv(CD), .DataWidth(8), .ParityEn(1), .ParityOdd(0), .StopBits(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_data(fdata[1]),
    .fifo_has_data(fhas[1]), .fifo_read(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx #(.ClkDiv(CD), .DataWidth(8), .ParityEn(1), .ParityOdd(1), .StopBits(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_data(fdata[2]),
    .fifo_has_data(fhas[2]), .fifo_read(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 3; i++) begin
      fhas[i]  = (fq[i].size() > 0);
      fdata[i] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  endtask

  task automatic push(input int i, input logic [7:0] w);
    fq[i].push_back(w);
    exp_q[i].push_back(w);
    refresh();
  endtask

  task automatic build_frame(input int i, input logic [7:0] w);
    int n;
    fr[i][0] = 1'b0;
    for (int b = 0; b < 8; b++) fr[i][1+b] = w[b];
    n = 9;
    if (par_en[i] != 0) begin
      fr[i][9] = (^w) ^ (par_odd[i] != 0);
      n = 10;
    end
    fr[i][n] = 1'b1;
    flen[i] = n + 1;
  endtask

  // One clock cycle: advance the model across the rising edge, then compare.
  task automatic tick();
    logic s_has [3];
    logic s_en;
    logic nmf;
    int   nmc;
    logic e_tx;
    logic [7:0] w;
    for (int i = 0; i < 3; i++) s_has[i] = fhas[i];
    s_en = tx_enable;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mf[i] = 1'b0;
        mc[i] = -1;
      end else begin
        nmf = ((mc[i] == -1 && !mf[i]) || mc[i] == flen[i]*CD - 1) && s_has[i] && s_en;
        nmc = mf[i] ? 0 : ((mc[i] == -1 || mc[i] == flen[i]*CD - 1) ? -1 : mc[i] + 1);
        // The DUT captured the head word on this edge; the FIFO pops now.
        if (mf[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        if (nmf) begin
          check($sformatf("sb_nonempty%0d", i), 8'(exp_q[i].size() > 0), 8'h01);
          w = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : 8'h00;
          build_frame(i, w);
        end
        mf[i] = nmf;
        mc[i] = nmc;
      end
      e_tx = (mc[i] >= 0) ? fr[i][mc[i]/CD] : 1'b1;
      check($sformatf("tx%0d_c%0d", i, mc[i]), tx_w[i], e_tx);
      check($sformatf("rd%0d", i), rd_w[i], mf[i]);
      check($sformatf("busy%0d_c%0d", i, mc[i]), busy_w[i], mf[i] || (mc[i] >= 0));
    end
    refresh();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mc[i] = -1;
      mf[i] = 1'b0;
      flen[i] = 10;
    end
    par_en  = '{0, 1, 1};
    par_odd = '{0, 0, 1};
    refresh();

    // Reset state.
    repeat (3) tick();
    rst_n = 1'b1;

    // Empty FIFO with transmit enabled: line idle, no pops.
    tx_enable = 1'b1;
    repeat (200) tick();

    // Single 0x55 frame without parity.
    push(0, 8'h55);
    repeat (50) tick();

    // 0xA5 with even and odd parity.
    push(1, 8'hA5);
    push(2, 8'hA5);
    repeat (50) tick();

    // Back-to-back words.
    push(0, 8'h01);
    push(0, 8'h80);
    repeat (100) tick();

    // tx_enable dropped during DATA of the first of two queued words.
    push(0, 8'h11);
    push(0, 8'h22);
    for (int k = 0; k < 100 && mc[0] != 12; k++) tick();
    check("reach_data_en", 8'(mc[0] == 12), 8'h01);
    tx_enable = 1'b0;
    repeat (100) tick();
    check("held_word_waiting", 8'(fq[0].size()), 8'h01);
    tx_enable = 1'b1;
    repeat (60) tick();

    // Asynchronous reset in the middle of DATA.
    push(0, 8'h3C);
    push(0, 8'hC3);
    for (int k = 0; k < 100 && mc[0] != 20; k++) tick();
    check("reach_data_rst", 8'(mc[0] == 20), 8'h01);
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx", tx_w[0], 1'b1);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_rd", rd_w[0], 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (60) tick();

    // Every queued word was popped exactly once.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fifo_drained%0d", i), 8'(fq[i].size()), 8'h00);
      check($sformatf("sb_drained%0d", i), 8'(exp_q[i].size()), 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
